// File: rtl/alu_pkg.sv
// Opcode/funct encodings and ALU function width shared by the issue stage, ALU and decoder.
package alu_pkg;
  localparam int ALU_FN_W = 6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
endpackage

// File: rtl/operand_fwd_mux.sv
// Source operand selection: r0 reads zero, then EX result, then WB result, then register file.
module operand_fwd_mux #(
  parameter int XLEN   = 32,
  parameter int FWD_EN = 1
) (
  input  logic [4:0]      idx,
  input  logic [XLEN-1:0] reg_val,
  input  logic            ex_en,
  input  logic [4:0]      ex_idx,
  input  logic [XLEN-1:0] ex_val,
  input  logic            wb_en,
  input  logic [4:0]      wb_idx,
  input  logic [XLEN-1:0] wb_val,
  output logic [XLEN-1:0] val
);
  always_comb begin
    val = reg_val;
    if (idx == 5'd0)
      val = '0;
    else if (FWD_EN != 0 && ex_en && ex_idx == idx)
      val = ex_val;
    else if (FWD_EN != 0 && wb_en && wb_idx == idx)
      val = wb_val;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// Registered ID/EX issue stage: operand forwarding, decode to ALU operands/function,
// single-entry output register with valid/ready handshake and flush.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int IMM_W   = 16,
  parameter int SHAMT_W = 5,
  parameter int FWD_EN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          in_opcode,
  input  logic [5:0]          in_funct,
  input  logic [4:0]          in_rs_idx,
  input  logic [4:0]          in_rt_idx,
  input  logic [XLEN-1:0]     in_rs_val,
  input  logic [XLEN-1:0]     in_rt_val,
  input  logic [SHAMT_W-1:0]  in_shamt,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic                fwd_ex_en,
  input  logic [4:0]          fwd_ex_idx,
  input  logic [XLEN-1:0]     fwd_ex_val,
  input  logic                fwd_wb_en,
  input  logic [4:0]          fwd_wb_idx,
  input  logic [XLEN-1:0]     fwd_wb_val,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_a,
  output logic [XLEN-1:0]     out_b,
  output logic [ALU_FN_W-1:0] out_funct,
  output logic                out_illegal
);
  logic [XLEN-1:0] rs_v, rt_v, imm_se, imm_ze, shamt_ze;
  logic [XLEN-1:0] a_dec, b_dec;
  logic [ALU_FN_W-1:0] fn_dec;
  logic ill_dec, accept;

  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     out_a_q, out_a_d, out_b_q, out_b_d;
  logic [ALU_FN_W-1:0] out_funct_q, out_funct_d;
  logic                out_illegal_q, out_illegal_d;

  operand_fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_rs_mux (
    .idx(in_rs_idx), .reg_val(in_rs_val),
    .ex_en(fwd_ex_en), .ex_idx(fwd_ex_idx), .ex_val(fwd_ex_val),
    .wb_en(fwd_wb_en), .wb_idx(fwd_wb_idx), .wb_val(fwd_wb_val),
    .val(rs_v)
  );

  operand_fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_rt_mux (
    .idx(in_rt_idx), .reg_val(in_rt_val),
    .ex_en(fwd_ex_en), .ex_idx(fwd_ex_idx), .ex_val(fwd_ex_val),
    .wb_en(fwd_wb_en), .wb_idx(fwd_wb_idx), .wb_val(fwd_wb_val),
    .val(rt_v)
  );

  assign imm_se   = {{(XLEN-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign imm_ze   = {{(XLEN-IMM_W){1'b0}}, in_imm};
  assign shamt_ze = {{(XLEN-SHAMT_W){1'b0}}, in_shamt};

  always_comb begin
    a_dec   = '0;
    b_dec   = '0;
    fn_dec  = '0;
    ill_dec = 1'b0;
    if (in_opcode == OP_RTYPE) begin
      case (in_funct)
        FN_SLL, FN_SRL, FN_SRA: begin
          a_dec = rt_v; b_dec = shamt_ze; fn_dec = in_funct;
        end
        FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
        FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
          a_dec = rs_v; b_dec = rt_v; fn_dec = in_funct;
        end
        default: ill_dec = 1'b1;
      endcase
    end else if (in_opcode[5:4] == 2'b10) begin
      // loads/stores: address generation is an unsigned add
      a_dec = rs_v; b_dec = imm_se; fn_dec = FN_ADDU;
    end else begin
      case (in_opcode)
        OP_ADDI:  begin a_dec = rs_v; b_dec = imm_se; fn_dec = FN_ADD;  end
        OP_ADDIU: begin a_dec = rs_v; b_dec = imm_se; fn_dec = FN_ADDU; end
        OP_SLTI:  begin a_dec = rs_v; b_dec = imm_se; fn_dec = FN_SLT;  end
        OP_SLTIU: begin a_dec = rs_v; b_dec = imm_se; fn_dec = FN_SLTU; end
        OP_ANDI:  begin a_dec = rs_v; b_dec = imm_ze; fn_dec = FN_AND;  end
        OP_ORI:   begin a_dec = rs_v; b_dec = imm_ze; fn_dec = FN_OR;   end
        OP_XORI:  begin a_dec = rs_v; b_dec = imm_ze; fn_dec = FN_XOR;  end
        OP_LUI:   begin a_dec = imm_ze << 16; fn_dec = FN_ADDU; end
        default:  ill_dec = 1'b1;
      endcase
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // flush wins over a same-cycle accept; data registers simply hold when not loading
  always_comb begin
    out_valid_d   = out_valid_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_funct_d   = out_funct_q;
    out_illegal_d = out_illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_a_d       = a_dec;
      out_b_d       = b_dec;
      out_funct_d   = fn_dec;
      out_illegal_d = ill_dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_funct_q   <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_funct_q   <= out_funct_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_funct   = out_funct_q;
  assign out_illegal = out_illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed checks of alu_issue_stage: reset, decode, forwarding, backpressure, flush.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [5:0]  in_opcode, in_funct;
  logic [4:0]  in_rs_idx, in_rt_idx;
  logic [31:0] in_rs_val, in_rt_val;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic        fwd_ex_en, fwd_wb_en;
  logic [4:0]  fwd_ex_idx, fwd_wb_idx;
  logic [31:0] fwd_ex_val, fwd_wb_val;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [5:0]  out_funct;
  logic        out_illegal;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct),
    .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_shamt(in_shamt), .in_imm(in_imm),
    .fwd_ex_en(fwd_ex_en), .fwd_ex_idx(fwd_ex_idx), .fwd_ex_val(fwd_ex_val),
    .fwd_wb_en(fwd_wb_en), .fwd_wb_idx(fwd_wb_idx), .fwd_wb_val(fwd_wb_val),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_funct(out_funct), .out_illegal(out_illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [31:0] rsv,
                       input logic [4:0] rt, input logic [31:0] rtv,
                       input logic [4:0] sh, input logic [15:0] imm);
    in_valid = 1'b1; in_opcode = op; in_funct = fn;
    in_rs_idx = rs; in_rs_val = rsv; in_rt_idx = rt; in_rt_val = rtv;
    in_shamt = sh; in_imm = imm;
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, out_a, out_b, out_funct, out_illegal, in_ready} !== {1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b1})
      $display("FAIL reset_state: got v=%b a=%h b=%h fn=%h ill=%b rdy=%b, want 0/0/0/0/0/1",
               out_valid, out_a, out_b, out_funct, out_illegal, in_ready);
    else passed++;
    rst = 1'b0;
    step();
    drive(6'h08, 6'h00, 5'd1, 32'h1234, 5'd0, 32'h0, 5'd0, 16'h0001);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_a !== 32'h1234)
      $display("FAIL reset_pre_hold: got v=%b a=%h, want 1/00001234", out_valid, out_a);
    else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_a, out_b, out_funct, out_illegal, in_ready} !== {1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b1})
      $display("FAIL reset_async: got v=%b a=%h b=%h fn=%h ill=%b rdy=%b, want 0/0/0/0/0/1",
               out_valid, out_a, out_b, out_funct, out_illegal, in_ready);
    else passed++;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_imm_decode();
    drive(6'h08, 6'h00, 5'd5, 32'h10, 5'd0, 32'h0, 5'd0, 16'hFFFF);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_a !== 32'h10 || out_b !== 32'hFFFFFFFF || out_funct !== 6'h20 || out_illegal !== 1'b0)
      $display("FAIL addi: got v=%b a=%h b=%h fn=%h ill=%b, want 1/00000010/ffffffff/20/0",
               out_valid, out_a, out_b, out_funct, out_illegal);
    else passed++;
    drive(6'h0D, 6'h00, 5'd5, 32'h10, 5'd0, 32'h0, 5'd0, 16'hFFFF);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_a !== 32'h10 || out_b !== 32'h0000FFFF || out_funct !== 6'h25)
      $display("FAIL ori: got v=%b a=%h b=%h fn=%h, want 1/00000010/0000ffff/25",
               out_valid, out_a, out_b, out_funct);
    else passed++;
    drive(6'h23, 6'h00, 5'd1, 32'h100, 5'd0, 32'h0, 5'd0, 16'hFFFC);
    step();
    checks++;
    if (out_a !== 32'h100 || out_b !== 32'hFFFFFFFC || out_funct !== 6'h21 || out_illegal !== 1'b0)
      $display("FAIL load: got a=%h b=%h fn=%h ill=%b, want 00000100/fffffffc/21/0",
               out_a, out_b, out_funct, out_illegal);
    else passed++;
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL drain: got v=%b, want 0", out_valid);
    else passed++;
  endtask

  task automatic test_forwarding();
    fwd_ex_en = 1'b1; fwd_ex_idx = 5'd3; fwd_ex_val = 32'hAA;
    fwd_wb_en = 1'b1; fwd_wb_idx = 5'd3; fwd_wb_val = 32'hBB;
    drive(6'h00, 6'h20, 5'd3, 32'h11, 5'd4, 32'h22, 5'd0, 16'h0);
    step();
    checks++;
    if (out_a !== 32'hAA || out_b !== 32'h22 || out_funct !== 6'h20)
      $display("FAIL fwd_ex_prio: got a=%h b=%h fn=%h, want 000000aa/00000022/20", out_a, out_b, out_funct);
    else passed++;
    fwd_ex_en = 1'b0;
    fwd_wb_idx = 5'd4; fwd_wb_val = 32'hCC;
    fwd_ex_en = 1'b1; fwd_ex_idx = 5'd7;
    step();
    checks++;
    if (out_a !== 32'h11 || out_b !== 32'hCC)
      $display("FAIL fwd_wb_rt: got a=%h b=%h, want 00000011/000000cc", out_a, out_b);
    else passed++;
    fwd_ex_idx = 5'd0; fwd_ex_val = 32'h77;
    fwd_wb_idx = 5'd0; fwd_wb_val = 32'h66;
    drive(6'h00, 6'h25, 5'd0, 32'h55, 5'd4, 32'h22, 5'd0, 16'h0);
    step();
    checks++;
    if (out_a !== 32'h0 || out_b !== 32'h22 || out_funct !== 6'h25)
      $display("FAIL fwd_r0: got a=%h b=%h fn=%h, want 00000000/00000022/25", out_a, out_b, out_funct);
    else passed++;
    fwd_ex_en = 1'b0; fwd_wb_en = 1'b0;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    drive(6'h08, 6'h00, 5'd1, 32'h1, 5'd0, 32'h0, 5'd0, 16'h0001);
    out_ready = 1'b0;
    step();
    drive(6'h08, 6'h00, 5'd1, 32'h2, 5'd0, 32'h0, 5'd0, 16'h0002);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_a !== 32'h1 || out_b !== 32'h1)
        $display("FAIL bp_hold%0d: got rdy=%b v=%b a=%h b=%h, want 0/1/00000001/00000001",
                 i, in_ready, out_valid, out_a, out_b);
      else passed++;
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL bp_ready: got rdy=%b, want 1", in_ready);
    else passed++;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_a !== 32'h2 || out_b !== 32'h2)
      $display("FAIL bp_next: got v=%b a=%h b=%h, want 1/00000002/00000002", out_valid, out_a, out_b);
    else passed++;
    step();
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL bp_nodup: got v=%b, want 0", out_valid);
    else passed++;
  endtask

  task automatic test_flush();
    drive(6'h08, 6'h00, 5'd1, 32'h7, 5'd0, 32'h0, 5'd0, 16'h0);
    step();
    drive(6'h00, 6'h22, 5'd1, 32'h9, 5'd2, 32'h3, 5'd0, 16'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL flush_accept: got v=%b, want 0", out_valid);
    else passed++;
    step();
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL flush_no_sub: got v=%b fn=%h, want v=0", out_valid, out_funct);
    else passed++;
    drive(6'h08, 6'h00, 5'd1, 32'h8, 5'd0, 32'h0, 5'd0, 16'h0);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL flush_held: got v=%b, want 0", out_valid);
    else passed++;
  endtask

  task automatic test_misc_decode();
    drive(6'h00, 6'h03, 5'd9, 32'h5, 5'd2, 32'h80000000, 5'd31, 16'h0);
    step();
    checks++;
    if (out_a !== 32'h80000000 || out_b !== 32'd31 || out_funct !== 6'h03 || out_illegal !== 1'b0)
      $display("FAIL sra: got a=%h b=%h fn=%h ill=%b, want 80000000/0000001f/03/0",
               out_a, out_b, out_funct, out_illegal);
    else passed++;
    drive(6'h3F, 6'h20, 5'd1, 32'h5, 5'd2, 32'h6, 5'd3, 16'h1234);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_a !== 32'h0 || out_b !== 32'h0 || out_funct !== 6'h0)
      $display("FAIL illegal_op: got v=%b ill=%b a=%h b=%h fn=%h, want 1/1/0/0/00",
               out_valid, out_illegal, out_a, out_b, out_funct);
    else passed++;
    drive(6'h00, 6'h01, 5'd1, 32'h5, 5'd2, 32'h6, 5'd0, 16'h0);
    step();
    checks++;
    if (out_illegal !== 1'b1 || out_funct !== 6'h0)
      $display("FAIL illegal_funct: got ill=%b fn=%h, want 1/00", out_illegal, out_funct);
    else passed++;
    drive(6'h0F, 6'h00, 5'd1, 32'h5, 5'd0, 32'h0, 5'd0, 16'h1234);
    step();
    checks++;
    if (out_a !== 32'h12340000 || out_b !== 32'h0 || out_funct !== 6'h21 || out_illegal !== 1'b0)
      $display("FAIL lui: got a=%h b=%h fn=%h ill=%b, want 12340000/00000000/21/0",
               out_a, out_b, out_funct, out_illegal);
    else passed++;
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_opcode = '0; in_funct = '0;
    in_rs_idx = '0; in_rt_idx = '0; in_rs_val = '0; in_rt_val = '0;
    in_shamt = '0; in_imm = '0;
    fwd_ex_en = 1'b0; fwd_ex_idx = '0; fwd_ex_val = '0;
    fwd_wb_en = 1'b0; fwd_wb_idx = '0; fwd_wb_val = '0;
    flush = 1'b0; out_ready = 1'b1;
    #1;
    test_reset();
    test_imm_decode();
    test_forwarding();
    test_backpressure();
    test_flush();
    test_misc_decode();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
